// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// control FSM state type and a word-alignment helper.
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// ---------------------------------------------------------------------------
// lsu_lane_mux
// Combinational big-endian lane steering shared by the load and RMW paths.
//   word        : 32-bit memory word (byte 0 lives in bits [31:24])
//   offset      : byte offset addr[1:0] of the access
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD
//   sign_ext    : 1 = sign-extend the extracted load value, 0 = zero-extend
//   wdata       : right-justified store data
//   load_data   : extracted and extended load value (0 for an illegal size)
//   merged_word : word with the addressed lane(s) replaced by wdata
// ---------------------------------------------------------------------------
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Lane gi holds the byte at offset gi (big-endian).
            localparam logic [1:0] LANE     = 2'(gi);
            localparam logic       LANE_HI  = (gi >= 2);
            localparam logic       LANE_ODD = ((gi % 2) == 1);

            logic       hit;
            logic [7:0] src;

            assign byte_lane[gi] = word[31-8*gi -: 8];

            always_comb begin
                hit = 1'b0;
                src = wdata[31-8*gi -: 8];
                case (size)
                    SZ_BYTE: begin
                        hit = (offset == LANE);
                        src = wdata[7:0];
                    end
                    SZ_HALF: begin
                        // Even lane takes the high byte of the halfword.
                        hit = (offset[1] == LANE_HI);
                        src = LANE_ODD ? wdata[7:0] : wdata[15:8];
                    end
                    SZ_WORD: hit = 1'b1;
                    default: hit = 1'b0;
                endcase
            end

            assign merged_word[31-8*gi -: 8] = hit ? src : byte_lane[gi];
        end
    endgenerate

    assign sel_byte = byte_lane[offset];
    assign sel_half = offset[1] ? word[15:0] : word[31:16];

    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
            SZ_WORD: load_data = word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage front end and sole master of a word-wide, byte-addressed data
// memory. Handles byte/half/word loads and stores, big-endian lane selection,
// sign/zero extension and read-modify-write for sub-word stores. Misaligned,
// illegal-size and out-of-range requests are answered with resp_error and
// never reach the memory.
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake (one request in flight)
//   req_write/size/signed/addr/wdata : request payload
//   resp_valid/rdata/error    : one-cycle completion pulse and result
//   busy                      : request in flight (pipeline stall)
//   mem_addr/wdata/we/re      : registered data-memory drive
//   mem_rdata                 : combinational read word from the memory
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    lsu_state_t  state_reg, state_next;
    logic        write_reg, signed_reg;
    logic [1:0]  size_reg, offset_reg;
    logic [31:0] wdata_reg;

    logic        mem_we_reg, mem_we_next;
    logic        mem_re_reg, mem_re_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic        resp_valid_reg, resp_valid_next;
    logic        resp_error_reg, resp_error_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data, merged_word;

    // Handshake outputs are gated by rst so they read 0 during reset even
    // before the first reset edge has cleared the state register.
    assign req_ready = !rst && (state_reg == IDLE);
    assign busy      = !rst && (state_reg != IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)                               req_err = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])           req_err = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
        if (word_align(req_addr) > LAST_WORD)               req_err = 1'b1;
    end

    // The lane mux always works on the live memory word; it is only consumed
    // in READ, when mem_rdata holds the word at the latched address.
    lsu_lane_mux u_lane_mux (
        .word        (mem_rdata),
        .offset      (offset_reg),
        .size        (size_reg),
        .sign_ext    (signed_reg),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            write_reg      <= 1'b0;
            signed_reg     <= 1'b0;
            size_reg       <= SZ_BYTE;
            offset_reg     <= 2'b00;
            wdata_reg      <= '0;
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_error_reg <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            if (accept) begin
                write_reg  <= req_write;
                signed_reg <= req_signed;
                size_reg   <= req_size;
                offset_reg <= req_addr[1:0];
                wdata_reg  <= req_wdata;
            end
            mem_we_reg     <= mem_we_next;
            mem_re_reg     <= mem_re_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_error_reg <= resp_error_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)                                  state_next = RESP;
                    else if (req_write && (req_size == SZ_WORD))  state_next = WRITE;
                    else                                          state_next = READ;
                end
            end
            READ:    state_next = write_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: values for the output flops are derived from the state
    // being entered, so every memory strobe is a clean flop output for
    // exactly the cycle spent in READ or WRITE.
    always_comb begin
        mem_re_next     = (state_next == READ);
        mem_we_next     = (state_next == WRITE);
        resp_valid_next = (state_next == RESP);
        resp_error_next = (state_reg == IDLE) && accept && req_err;
        resp_rdata_next = ((state_reg == READ) && !write_reg) ? load_data : '0;

        mem_addr_next = mem_addr_reg;
        if (accept && !req_err)
            mem_addr_next = word_align(req_addr);

        mem_wdata_next = mem_wdata_reg;
        if ((state_reg == IDLE) && (state_next == WRITE))
            mem_wdata_next = req_wdata;
        else if ((state_reg == READ) && (state_next == WRITE))
            mem_wdata_next = merged_word;
    end

    assign mem_we     = mem_we_reg;
    assign mem_re     = mem_re_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_error = resp_error_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench for load_store_unit: the stimulus process computes each
// expected response from a byte-array reference memory and queues it; a
// monitor checks memory strobes and responses as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int MEM_BYTES = 32;
    localparam int AW        = $clog2(MEM_BYTES);
    localparam int WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory seen by the DUT: combinational read, whole-word write.
    function automatic logic [31:0] init_word(input int k);
        return (32'h0101_0101 * 32'(k + 1)) ^ 32'hA5C3_5A3C;
    endfunction

    logic        mem_init = 1'b1;
    logic [31:0] dmem [WORDS];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < WORDS; k++) dmem[k] <= init_word(k);
        end else if (mem_we) begin
            dmem[mem_addr[AW-1:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr[AW-1:2]];

    // ---------------------------------------------------------------
    // Checking infrastructure
    // ---------------------------------------------------------------
    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wword;
        logic        err;
        int          lat;
        int          exp_re;
        int          exp_we;
        int          acc;
    } exp_t;

    exp_t sb[$];

    // Reference memory, big-endian: byte at address n is ref_mem[n].
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic void model(input bit w, input logic [1:0] sz, input bit sg,
                                  input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int idx, base, v;
        e.w = w; e.sz = sz; e.a = a;
        e.rdata = '0; e.wword = '0; e.acc = 0;
        e.addr  = a - (a % 4);
        e.err   = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
                  (sz == 2'd2 && (a % 4) != 0) || (a >= MEM_BYTES);
        e.exp_re = 0; e.exp_we = 0;
        if (e.err) begin
            e.lat = 1;
            return;
        end
        idx  = int'(a);
        base = idx - (idx % 4);
        if (w) begin
            case (sz)
                2'd0: ref_mem[idx] = wd[7:0];
                2'd1: begin ref_mem[idx] = wd[15:8]; ref_mem[idx+1] = wd[7:0]; end
                default: begin
                    ref_mem[idx] = wd[31:24]; ref_mem[idx+1] = wd[23:16];
                    ref_mem[idx+2] = wd[15:8]; ref_mem[idx+3] = wd[7:0];
                end
            endcase
            e.wword  = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
            e.exp_we = 1;
            e.exp_re = (sz == 2'd2) ? 0 : 1;
            e.lat    = (sz == 2'd2) ? 2 : 3;
        end else begin
            case (sz)
                2'd0: begin
                    v = int'(ref_mem[idx]);
                    if (sg && v >= 128) v -= 256;
                end
                2'd1: begin
                    v = int'(ref_mem[idx]) * 256 + int'(ref_mem[idx+1]);
                    if (sg && v >= 32768) v -= 65536;
                end
                default: v = int'({ref_mem[idx], ref_mem[idx+1], ref_mem[idx+2], ref_mem[idx+3]});
            endcase
            e.rdata  = 32'(v);
            e.exp_re = 1;
            e.lat    = 2;
        end
    endfunction

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    bit aborting = 1'b0;
    int abort_we = 0;
    int abort_resp = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    int txn = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            if (mem_re || mem_we) begin
                if (aborting) begin
                    if (mem_we) abort_we++;
                end else if (sb.size() == 0) begin
                    chk("unexpected_mem_access", 32'(sb.size()), 32'd1);
                end else begin
                    chk("mem_addr", mem_addr, sb[0].addr);
                    if (mem_we) chk("mem_wdata", mem_wdata, sb[0].wword);
                    if (mem_re) re_cnt++;
                    if (mem_we) we_cnt++;
                end
            end
            if (resp_valid) begin
                if (aborting) begin
                    abort_resp++;
                end else if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_error", 32'(resp_error), 32'(e.err));
                    chk("resp_latency", 32'(cyc), 32'(e.acc + e.lat - 1));
                    chk("mem_re_cycles", 32'(re_cnt), 32'(e.exp_re));
                    chk("mem_we_cycles", 32'(we_cnt), 32'(e.exp_we));
                    txn++;
                    $display("txn %0d: %s size=%0d addr=0x%08h rdata=0x%08h err=%0d cycle=%0d",
                             txn, e.w ? "store" : "load ", e.sz, e.a, resp_rdata, resp_error, cyc);
                    re_cnt = 0;
                    we_cnt = 0;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, input bit abort, output int acc);
        exp_t e;
        int n;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            chk("busy_while_stalled", 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (!abort) begin
            model(w, sz, sg, a, wd, e);
            e.acc = acc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic op(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                      input logic [31:0] wd);
        int acc;
        issue(w, sz, sg, a, wd, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int acc1, acc2, acc_ab;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int k = 0; k < WORDS; k++) begin
            logic [31:0] iw;
            iw = init_word(k);
            ref_mem[4*k]   = iw[31:24];
            ref_mem[4*k+1] = iw[23:16];
            ref_mem[4*k+2] = iw[15:8];
            ref_mem[4*k+3] = iw[7:0];
        end

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_mem_we",     32'(mem_we),     32'd0);
        chk("rst_mem_re",     32'(mem_re),     32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'd0);
        chk("rst_mem_addr",   mem_addr,        32'd0);
        chk("rst_mem_wdata",  mem_wdata,       32'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_busy",      32'(busy),      32'd0);

        // Word store then loads of every width.
        op(1'b1, 2'd2, 1'b0, 32'd8,  32'hDEADBEEF);
        op(1'b0, 2'd2, 1'b0, 32'd8,  32'h0);
        op(1'b0, 2'd0, 1'b0, 32'd9,  32'h0);
        op(1'b0, 2'd0, 1'b1, 32'd8,  32'h0);
        op(1'b0, 2'd0, 1'b1, 32'd11, 32'h0);
        op(1'b0, 2'd1, 1'b0, 32'd10, 32'h0);
        op(1'b0, 2'd1, 1'b1, 32'd10, 32'h0);
        // Halfword RMW store.
        op(1'b1, 2'd1, 1'b0, 32'd10, 32'h00001234);
        op(1'b0, 2'd2, 1'b0, 32'd8,  32'h0);
        // Errors.
        op(1'b0, 2'd2, 1'b0, 32'd6,  32'h0);
        op(1'b1, 2'd1, 1'b0, 32'd9,  32'h5555);
        op(1'b0, 2'd3, 1'b0, 32'd0,  32'h0);
        op(1'b0, 2'd2, 1'b0, 32'd32, 32'h0);
        op(1'b1, 2'd0, 1'b0, 32'd28, 32'h77);

        // Back-to-back: req_valid stays high across two loads.
        issue(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 1'b1, 1'b0, acc1);
        issue(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, 1'b0, 1'b0, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);

        // Reset abort of a byte store during its READ cycle.
        drain();
        aborting = 1'b1;
        issue(1'b1, 2'd0, 1'b0, 32'd4, 32'h000000AA, 1'b0, 1'b1, acc_ab);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy",      32'(busy),      32'd0);
        repeat (4) @(negedge clk);
        aborting = 1'b0;
        chk("abort_mem_we",     32'(abort_we),   32'd0);
        chk("abort_resp_valid", 32'(abort_resp), 32'd0);
        op(1'b0, 2'd2, 1'b0, 32'd4, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 2) != 0) begin
                if (sz == 2'd1) a = a - (a % 2);
                if (sz == 2'd2) a = a - (a % 4);
            end
            if ($urandom_range(0, 9) == 0)  a = a + MEM_BYTES;
            if ($urandom_range(0, 24) == 0) a = $urandom();
            op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
